// File: rtl/bit_axi_store_buffer_pkg.sv
// Shared types and constants for the posted-write store buffer:
// FSM encodings, AXI field constants and the store-entry layout.
package bit_axi_store_buffer_pkg;

   localparam int SB_ADDR_W = 30;
   localparam int SB_STRB_W = 4;
   localparam int SB_DATA_W = 32;

   localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   typedef enum logic [1:0] {
      SB_STATE_IDLE   = 2'd0,
      SB_STATE_SEND   = 2'd1,
      SB_STATE_WAIT_B = 2'd2
   } sb_state_e;

   // Word address only; the byte offset is carried by strb.
   typedef struct packed {
      logic [SB_ADDR_W-1:0] addr;
      logic [SB_STRB_W-1:0] strb;
      logic [SB_DATA_W-1:0] data;
   } sb_entry_t;

endpackage

// File: rtl/bit_sb_fifo.sv
// DEPTH-entry register FIFO of store entries. Exposes the head, the read
// pointer and every entry with its occupancy bit for the load hazard compare.
module bit_sb_fifo
   import bit_axi_store_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  sb_entry_t              push_entry,
   input  logic                   pop,
   output sb_entry_t              head,
   output logic [PTR_W:0]         count,
   output logic [PTR_W-1:0]       rd_ptr,
   output logic [DEPTH-1:0]       ent_valid,
   output sb_entry_t [DEPTH-1:0]  ent
);

   logic [PTR_W-1:0] wr_ptr;

   // Push is never offered when full and pop never when empty, so a
   // simultaneous push/pop never targets the same slot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         ent_valid <= '0;
         ent       <= '0;
      end else begin
         if (push) begin
            ent[wr_ptr]       <= push_entry;
            ent_valid[wr_ptr] <= 1'b1;
            wr_ptr            <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            ent_valid[rd_ptr] <= 1'b0;
            rd_ptr            <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign head = ent[rd_ptr];

endmodule

// File: rtl/bit_axi_store_buffer.sv
// Posted-write store buffer driving AXI AW/W/B, one single-beat write per
// entry in push order. Optional load forwarding under SB_LD_FWD_EN.
module bit_axi_store_buffer
   import bit_axi_store_buffer_pkg::*;
#(
   parameter int          DEPTH  = 4,
   parameter int          PTR_W  = 2,
   parameter logic [3:0]  AXI_ID = 4'b0001
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [31:0]       st_addr,
   input  logic [3:0]        st_strb,
   input  logic [31:0]       st_data,
   input  logic [31:0]       ld_addr,
   output logic              ld_hit,
`ifdef SB_LD_FWD_EN
   output logic              ld_fwd_valid,
   output logic [31:0]       ld_fwd_data,
`endif
   output logic              sb_empty,
   output logic [PTR_W:0]    sb_count,
   output logic              bus_err,
   output sb_state_e         state_dbg,
   output logic [3:0]        awid,
   output logic [31:0]       awaddr,
   output logic [7:0]        awlen,
   output logic [2:0]        awsize,
   output logic [1:0]        awburst,
   output logic [1:0]        awlock,
   output logic [3:0]        awcache,
   output logic [2:0]        awprot,
   output logic              awvalid,
   input  logic              awready,
   output logic [3:0]        wid,
   output logic [31:0]       wdata,
   output logic [3:0]        wstrb,
   output logic              wlast,
   output logic              wvalid,
   input  logic              wready,
   input  logic [3:0]        bid,
   input  logic [1:0]        bresp,
   input  logic              bvalid,
   output logic              bready
);

   sb_state_e              state, state_n;
   logic                   awvalid_n, wvalid_n, bready_n;
   logic                   aw_done, aw_done_n, w_done, w_done_n;
   logic                   bus_err_n;
   logic                   push, pop;
   sb_entry_t              push_entry, head;
   logic [PTR_W-1:0]       rd_ptr;
   logic [DEPTH-1:0]       ent_valid, hit_vec;
   sb_entry_t [DEPTH-1:0]  ent;
   logic                   any_hit;

   assign st_ready   = (sb_count != (PTR_W+1)'(DEPTH));
   assign push       = st_valid && st_ready && (st_strb != 4'b0000);
   assign push_entry = '{addr: st_addr[31:2], strb: st_strb, data: st_data};
   assign sb_empty   = (sb_count == '0);

   bit_sb_fifo #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .count      (sb_count),
      .rd_ptr     (rd_ptr),
      .ent_valid  (ent_valid),
      .ent        (ent)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= SB_STATE_IDLE;
         awvalid <= 1'b0;
         wvalid  <= 1'b0;
         bready  <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         bus_err <= 1'b0;
      end else begin
         state   <= state_n;
         awvalid <= awvalid_n;
         wvalid  <= wvalid_n;
         bready  <= bready_n;
         aw_done <= aw_done_n;
         w_done  <= w_done_n;
         bus_err <= bus_err_n;
      end
   end

   // valid/ready: a channel transfers on any cycle where both are high; a
   // raised valid and its payload (taken from the head) hold until then.
   always_comb begin
      state_n   = state;
      awvalid_n = awvalid;
      wvalid_n  = wvalid;
      bready_n  = bready;
      aw_done_n = aw_done;
      w_done_n  = w_done;
      bus_err_n = bus_err;
      pop       = 1'b0;
      case (state)
         SB_STATE_IDLE: begin
            if (sb_count != '0) begin
               state_n   = SB_STATE_SEND;
               awvalid_n = 1'b1;
               wvalid_n  = 1'b1;
            end
         end
         SB_STATE_SEND: begin
            if (awvalid && awready) begin
               awvalid_n = 1'b0;
               aw_done_n = 1'b1;
            end
            if (wvalid && wready) begin
               wvalid_n = 1'b0;
               w_done_n = 1'b1;
            end
            if (aw_done_n && w_done_n) begin
               state_n  = SB_STATE_WAIT_B;
               bready_n = 1'b1;
            end
         end
         SB_STATE_WAIT_B: begin
            if (bvalid && bready) begin
               pop       = 1'b1;
               bready_n  = 1'b0;
               aw_done_n = 1'b0;
               w_done_n  = 1'b0;
               state_n   = SB_STATE_IDLE;
               if (bresp != AXI_RESP_OKAY) bus_err_n = 1'b1;
            end
         end
         default: state_n = SB_STATE_IDLE;
      endcase
   end

   assign state_dbg = state;

   assign awid    = AXI_ID;
   assign awaddr  = {head.addr, 2'b00};
   assign awlen   = 8'd0;
   assign awsize  = AXI_SIZE_WORD;
   assign awburst = AXI_BURST_INCR;
   assign awlock  = 2'b00;
   assign awcache = 4'b0000;
   assign awprot  = 3'b000;
   assign wid     = AXI_ID;
   assign wdata   = head.data;
   assign wstrb   = head.strb;
   assign wlast   = 1'b1;

   // The in-flight head stays occupied until its B, so it is compared too.
   always_comb begin
      hit_vec = '0;
      for (int i = 0; i < DEPTH; i++)
         hit_vec[i] = ent_valid[i] && (ent[i].addr == ld_addr[31:2]);
   end
   assign any_hit = |hit_vec;

`ifdef SB_LD_FWD_EN
   logic              fwd_found;
   sb_entry_t         fwd_entry;
   logic [PTR_W-1:0]  fwd_idx;

   // Walk from oldest to youngest; the last match wins.
   always_comb begin
      fwd_found = 1'b0;
      fwd_entry = '0;
      fwd_idx   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         fwd_idx = rd_ptr + PTR_W'(k);
         if (hit_vec[fwd_idx]) begin
            fwd_found = 1'b1;
            fwd_entry = ent[fwd_idx];
         end
      end
   end

   assign ld_fwd_valid = fwd_found && (fwd_entry.strb == 4'b1111);
   assign ld_fwd_data  = fwd_entry.data;
   assign ld_hit       = any_hit && !ld_fwd_valid;

   logic unused_bits;
   assign unused_bits = ^{st_addr[1:0], ld_addr[1:0], bid};
`else
   assign ld_hit = any_hit;

   logic unused_bits;
   assign unused_bits = ^{st_addr[1:0], ld_addr[1:0], bid, rd_ptr, ent};
`endif

endmodule

// File: doc/bit_axi_store_buffer.md
Name: bit_axi_store_buffer

Overview:
- Posted-write store buffer between the CPU data-side SRAM-like store port and the AXI write channels (AW/W/B).
- Sits beside the read-only AXI bridge, which drives AR/R only; together they form the full AXI master.
- Accepts word stores into a small FIFO, drains one single-beat AXI write per entry in order, and flags read-after-write hazards to the load path.

Parameters:
- DEPTH, 4, number of store entries; power of two, 2..16.
- PTR_W, 2, pointer width; equals log2(DEPTH).
- AXI_ID, 4'b0001, ID driven on awid/wid.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- st_valid  in  1  store request from the data port
- st_ready  out  1  buffer can accept a store this cycle
- st_addr  in  32  store byte address; bits [1:0] are ignored for the AXI address
- st_strb  in  4  byte enables; 4'b0000 is never pushed
- st_data  in  32  store data, lane-aligned
- ld_addr  in  32  current load address from the data port
- ld_hit  out  1  a pending store matches ld_addr[31:2]
- sb_empty  out  1  no pending stores, including the in-flight head
- sb_count  out  PTR_W+1  number of occupied entries
- bus_err  out  1  sticky flag: a non-OKAY bresp was received
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  4/32/8/3/2/2/4/3/1  AXI AW
- awready  in  1
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  AXI W
- wready  in  1
- bid  in  4
- bresp  in  2
- bvalid  in  1
- bready  out  1

Behaviour:
- Reset (rst low, asynchronous):
  - Pointers 0, sb_count 0, sb_empty 1, st_ready 1.
  - awvalid 0, wvalid 0, bready 0, bus_err 0.
  - State IDLE; aw_done and w_done cleared.
- Push:
  - Condition: st_valid && st_ready && st_strb != 0.
  - The entry {addr[31:2], strb, data} is written at the tail on that clock edge.
  - st_ready = (sb_count != DEPTH), registered-count based; there is no same-cycle pass-through when full.
- Pop: the head entry is freed on the cycle bvalid && bready is seen.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- FSM:
  - IDLE: if count != 0, go to SEND and register awvalid = wvalid = 1 from the head. An entry pushed into an empty buffer in cycle N gives awvalid high in cycle N+2 (N+1: IDLE sees count != 0; N+2: SEND).
  - SEND:
    - awvalid drops the cycle after awvalid && awready, and aw_done is set.
    - wvalid drops the cycle after wvalid && wready, and w_done is set.
    - AW and W may complete in either order or in the same cycle.
    - When both are done (counting the current cycle's handshakes), go to WAIT_B with bready = 1.
  - WAIT_B: on bvalid, pop, set bready = 0, clear the done flags, go to IDLE. Back-to-back entries therefore cost one IDLE cycle each.
- AXI field values:
  - AW: awaddr = {head.addr, 2'b00}, awlen 0, awsize 3'b010, awburst 2'b01, awlock 0, awcache 0, awprot 0, awid = AXI_ID.
  - W: wdata = head.data, wstrb = head.strb, wlast 1, wid = AXI_ID.
  - valid stability: once awvalid or wvalid is asserted, it and its payload stay stable until the handshake.
- bresp:
  - bresp != 2'b00 sets bus_err, which stays set until reset.
  - The entry is still popped; no retry.
  - bid is not checked.
- Hazard:
  - ld_hit is combinational: OR over all occupied entries (the in-flight head included until its B) of entry.addr == ld_addr[31:2].
  - The load path stalls its read while ld_hit is 1.
- No flush input: accepted stores are architecturally committed and always drain.

Optional Feature:
- Macro: SB_LD_FWD_EN.
- Defined:
  - Adds outputs ld_fwd_valid (1) and ld_fwd_data (32).
  - Forwarding uses the youngest matching entry.
  - ld_fwd_valid = 1 when that entry's strb == 4'b1111; ld_fwd_data is that entry's data.
  - ld_hit is forced to 0 whenever ld_fwd_valid is 1.
- Undefined: neither port exists; hazard handling is by stall only.

Decomposition:
- Shared package/defines.v:
  - SB_STATE_IDLE/SEND/WAIT_B encodings.
  - AXI constants AXI_SIZE_WORD 3'b010, AXI_BURST_INCR 2'b01, AXI_RESP_OKAY 2'b00.
  - Store-entry field widths (addr 30, strb 4, data 32).
- One sub-module: bit_sb_fifo, a DEPTH-entry register FIFO exposing head, tail write, and per-entry valid/addr/data vectors for the hazard compare.
- The FSM and the AXI logic stay in the top module.

Test Plan:
- Single store: st_addr 0x1FC0_0104, strb 4'hF, data 0xDEAD_BEEF, awready/wready 1.
  -> awaddr 0x1FC0_0104, wdata 0xDEAD_BEEF, wstrb F in cycle N+2; B in cycle N+4.
  -> sb_empty returns to 1.
- Push 5 stores with awready held 0.
  -> st_ready 0 after the 4th store; sb_count 4; the 5th store is held.
  -> Release awready: AXI writes are issued in push order and the 5th store is accepted.
- W before AW: wready 1, awready delayed 3 cycles.
  -> wvalid drops after 1 cycle, awvalid stays stable for 3 cycles, then WAIT_B.
  -> No duplicate W beat.
- Hazard: buffer holds 0x8000_0010; ld_addr 0x8000_0013 -> ld_hit 1.
  -> ld_addr 0x8000_0014 -> ld_hit 0.
  -> After B for that entry -> ld_hit 0.
- bresp 2'b10 on the first write: bus_err 1, the entry is popped, the second write proceeds normally, bus_err stays 1.
- Async reset asserted during SEND with awvalid 1: awvalid 0 immediately, count 0.
  -> After release: IDLE, no AXI activity until a new push.
